// File: rtl/mic1_mem_ctrl.sv
// mic1_mem_ctrl: memory-port controller for the Mic-1 datapath.
// Turns the MIR memory field (WRITE/READ/FETCH) into transactions on one
// main-memory port. It keeps a DATA slot and a FETCH slot, allows one
// outstanding transaction at a time, and stalls the microsequencer whenever
// the two-cycle memory contract cannot be met.
// Optional feature: define MIC1_FETCH_BUF_EN to add a one-word fetch buffer.
module mic1_mem_ctrl #(
    parameter int unsigned FETCH_FIRST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_i,
    input  logic [2:0]  mem_ctrl_i,
    input  logic [31:0] mar_i,
    input  logic [31:0] mdr_i,
    input  logic [31:0] pc_i,
    output logic        stall_o,
    output logic        mdr_load_o,
    output logic [31:0] mdr_data_o,
    output logic        mbr_load_o,
    output logic [7:0]  mbr_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;

    logic        data_vld_q;
    logic        data_we_q;
    logic [29:0] data_addr_q;
    logic [31:0] data_wdata_q;
    logic        fetch_vld_q;
    logic [31:0] fetch_addr_q;
    logic        sel_fetch_q;
    logic        lock_q;
    logic        err_q;

    logic        sel_fetch;
    logic        complete;
    logic        data_done;
    logic        fetch_done;
    logic        do_issue;
    logic        iss_wr;
    logic        iss_data;
    logic        iss_fetch;
    logic        fetch_to_mem;
    logic        any_fill;
    logic        unused_mar;

    // Upper MAR bits fall off the word-to-byte address shift.
    assign unused_mar = ^mar_i[31:30];

    // Big-endian byte lane: lane 0 is the most significant byte.
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // WRITE dominates READ when both are set; the READ is dropped.
    assign do_issue  = issue_i & ~stall_o;
    assign iss_wr    = mem_ctrl_i[2];
    assign iss_data  = mem_ctrl_i[2] | mem_ctrl_i[1];
    assign iss_fetch = mem_ctrl_i[0];
    assign any_fill  = do_issue & (iss_data | fetch_to_mem);

    // Arbitration, completion and stall; the grant is frozen while a request waits.
    always_comb begin
        sel_fetch = 1'b0;
        complete  = 1'b0;
        if (lock_q) begin
            sel_fetch = sel_fetch_q;
        end else if (data_vld_q && fetch_vld_q) begin
            sel_fetch = (FETCH_FIRST != 0);
        end else begin
            sel_fetch = fetch_vld_q;
        end
        complete   = (state_q == StBusy) && mem_ready_i;
        data_done  = complete && !sel_fetch;
        fetch_done = complete && sel_fetch;
        stall_o    = (data_vld_q && !data_done) || (fetch_vld_q && !fetch_done);
    end

    // FSM next state and request valid.
    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_fill) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                mem_req_o = 1'b1;
                if (complete) begin
                    state_d = (stall_o || any_fill) ? StBusy : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot fill/clear, grant freeze and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_vld_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            fetch_vld_q  <= 1'b0;
            fetch_addr_q <= '0;
            sel_fetch_q  <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (do_issue && iss_data) begin
                data_vld_q   <= 1'b1;
                data_we_q    <= iss_wr;
                data_addr_q  <= mar_i[29:0];
                data_wdata_q <= mdr_i;
            end else if (data_done) begin
                data_vld_q <= 1'b0;
            end
            if (do_issue && fetch_to_mem) begin
                fetch_vld_q  <= 1'b1;
                fetch_addr_q <= pc_i;
            end else if (fetch_done) begin
                fetch_vld_q <= 1'b0;
            end
            sel_fetch_q <= sel_fetch;
            lock_q      <= mem_req_o && !mem_ready_i;
            if (do_issue && mem_ctrl_i[2] && mem_ctrl_i[1]) begin
                err_q <= 1'b1;
            end
        end
    end

    // Memory port and MDR return; idle outputs are forced to zero.
    always_comb begin
        mem_we_o    = mem_req_o && !sel_fetch && data_we_q;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_addr_o = sel_fetch ? {fetch_addr_q[31:2], 2'b00} : {data_addr_q, 2'b00};
        end
        if (mem_we_o) begin
            mem_wdata_o = data_wdata_q;
        end
        mdr_load_o = data_done && !data_we_q;
        mdr_data_o = mdr_load_o ? mem_rdata_i : 32'd0;
    end

    assign err_o = err_q;

`ifdef MIC1_FETCH_BUF_EN
    logic        buf_vld_q, buf_vld_d;
    logic [29:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        hit_q;
    logic [7:0]  hit_byte_q;
    logic        fetch_hit;

    // Buffer contents after this edge: fill on fetch return, drop on write to the tag.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        if (fetch_done) begin
            buf_vld_d  = 1'b1;
            buf_tag_d  = fetch_addr_q[31:2];
            buf_data_d = mem_rdata_i;
        end else if (data_done && data_we_q && (data_addr_q == buf_tag_q)) begin
            buf_vld_d = 1'b0;
        end
    end

    // A write issued alongside to the same word forces the fetch to memory.
    assign fetch_hit    = buf_vld_d && (buf_tag_d == pc_i[31:2]) &&
                          !(iss_wr && (mar_i[29:0] == pc_i[31:2]));
    assign fetch_to_mem = iss_fetch && !fetch_hit;

    // Buffer registers and the one-cycle hit return.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
            hit_q      <= 1'b0;
            hit_byte_q <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
            hit_q      <= do_issue && iss_fetch && fetch_hit;
            hit_byte_q <= sel_byte(buf_data_d, pc_i[1:0]);
        end
    end

    // MBR return from memory or from a buffer hit.
    always_comb begin
        mbr_load_o = fetch_done || hit_q;
        mbr_data_o = 8'd0;
        if (fetch_done) begin
            mbr_data_o = sel_byte(mem_rdata_i, fetch_addr_q[1:0]);
        end else if (hit_q) begin
            mbr_data_o = hit_byte_q;
        end
    end
`else
    assign fetch_to_mem = iss_fetch;

    // MBR return from memory.
    always_comb begin
        mbr_load_o = fetch_done;
        mbr_data_o = fetch_done ? sel_byte(mem_rdata_i, fetch_addr_q[1:0]) : 8'd0;
    end
`endif

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// tb_mic1_mem_ctrl: randomized bench for mic1_mem_ctrl against a queue-based
// transaction model, plus directed checks with hand-computed values.
// A second instance with FETCH_FIRST=1 and a zero-wait memory shows the swapped order.
module tb_mic1_mem_ctrl;

    localparam int unsigned TbFetchFirst = 0;

    logic        clk;
    logic        reset;
    logic        issue;
    logic [2:0]  mem_ctrl;
    logic [31:0] mar, mdr, pc;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        stall_o, mdr_load_o, mbr_load_o, mem_req_o, mem_we_o, err_o;
    logic [31:0] mdr_data_o, mem_addr_o, mem_wdata_o;
    logic [7:0]  mbr_data_o;

    logic        ff_stall, ff_mdr_load, ff_mbr_load, ff_req, ff_we, ff_err;
    logic [31:0] ff_mdr_data, ff_addr, ff_wdata;
    logic [7:0]  ff_mbr_data;

    mic1_mem_ctrl #(.FETCH_FIRST(TbFetchFirst)) u_dut (
        .clk(clk), .reset(reset), .issue_i(issue), .mem_ctrl_i(mem_ctrl),
        .mar_i(mar), .mdr_i(mdr), .pc_i(pc),
        .stall_o(stall_o), .mdr_load_o(mdr_load_o), .mdr_data_o(mdr_data_o),
        .mbr_load_o(mbr_load_o), .mbr_data_o(mbr_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .err_o(err_o)
    );

    mic1_mem_ctrl #(.FETCH_FIRST(1)) u_dut_ff (
        .clk(clk), .reset(reset), .issue_i(issue), .mem_ctrl_i(mem_ctrl),
        .mar_i(mar), .mdr_i(mdr), .pc_i(pc),
        .stall_o(ff_stall), .mdr_load_o(ff_mdr_load), .mdr_data_o(ff_mdr_data),
        .mbr_load_o(ff_mbr_load), .mbr_data_o(ff_mbr_data),
        .mem_req_o(ff_req), .mem_we_o(ff_we), .mem_addr_o(ff_addr),
        .mem_wdata_o(ff_wdata), .mem_ready_i(1'b1), .mem_rdata_i(mem_rdata),
        .err_o(ff_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] l);
        logic [31:0] s;
        s = w >> (8 * (3 - int'(l)));
        return s[7:0];
    endfunction

    // Model: queue of memory transactions still owed, in service order.
    typedef struct {
        logic        we;
        logic        fetch;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  lane;
    } txn_t;

    txn_t        q[$];
    bit          m_live = 0;
    bit          m_err;
    bit          m_buf_vld;
    logic [29:0] m_buf_tag;
    logic [31:0] m_buf_data;
    bit          m_hit;
    logic [7:0]  m_hit_byte;

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        txn_t dt, ft, t;
        bit   stall_now, w, r, f, hit;
        if (reset) begin
            q.delete();
            m_err     = 0;
            m_buf_vld = 0;
            m_hit     = 0;
            m_live    = 1;
            return;
        end
        stall_now = q.size() > (mem_ready ? 1 : 0);
        m_hit = 0;
        if (mem_ready && q.size() > 0) begin
            t = q.pop_front();
            if (t.fetch) begin
                m_buf_vld  = 1;
                m_buf_tag  = t.addr[31:2];
                m_buf_data = mem_rdata;
            end else if (t.we && t.addr[31:2] == m_buf_tag) begin
                m_buf_vld = 0;
            end
        end
        if (issue && !stall_now) begin
            w = mem_ctrl[2];
            r = mem_ctrl[1] && !w;
            f = mem_ctrl[0];
            if (mem_ctrl[2] && mem_ctrl[1]) m_err = 1;
            hit = 0;
`ifdef MIC1_FETCH_BUF_EN
            hit = f && m_buf_vld && (m_buf_tag == pc[31:2]) && !(w && mar[29:0] == pc[31:2]);
`endif
            dt = '{we: w, fetch: 1'b0, addr: {mar[29:0], 2'b00}, wdata: mdr, lane: 2'd0};
            ft = '{we: 1'b0, fetch: 1'b1, addr: {pc[31:2], 2'b00}, wdata: 32'd0, lane: pc[1:0]};
            if (TbFetchFirst != 0) begin
                if (f && !hit) q.push_back(ft);
                if (w || r) q.push_back(dt);
            end else begin
                if (w || r) q.push_back(dt);
                if (f && !hit) q.push_back(ft);
            end
            if (hit) begin
                m_hit      = 1;
                m_hit_byte = lane_of(m_buf_data, pc[1:0]);
            end
        end
    endtask

    // Compare every DUT output with the model in the middle of each cycle.
    initial begin
        int   n;
        bit   comp, has;
        txn_t h;
        forever begin
            @(negedge clk);
            if (m_live) begin
                n    = q.size();
                has  = (n > 0);
                comp = mem_ready && has;
                if (has) h = q[0];
                else h = '{we: 1'b0, fetch: 1'b0, addr: 32'd0, wdata: 32'd0, lane: 2'd0};
                chk("mem_req", 32'(mem_req_o), 32'(has));
                chk("mem_addr", mem_addr_o, has ? h.addr : 32'd0);
                chk("mem_we", 32'(mem_we_o), 32'(has && h.we));
                chk("mem_wdata", mem_wdata_o, (has && h.we) ? h.wdata : 32'd0);
                chk("stall", 32'(stall_o), 32'((n - int'(comp)) > 0));
                chk("mdr_load", 32'(mdr_load_o), 32'(comp && !h.fetch && !h.we));
                chk("mdr_data", mdr_data_o, (comp && !h.fetch && !h.we) ? mem_rdata : 32'd0);
                chk("mbr_load", 32'(mbr_load_o), 32'(m_hit || (comp && h.fetch)));
                chk("mbr_data", 32'(mbr_data_o),
                    m_hit ? 32'(m_hit_byte) :
                    (comp && h.fetch) ? 32'(lane_of(mem_rdata, h.lane)) : 32'd0);
                chk("err", 32'(err_o), 32'(m_err));
            end
        end
    end

    // One clock of stimulus: model sees the old inputs at the edge, then new ones are driven.
    task automatic drive(input bit iss, input logic [2:0] ctrl, input logic [31:0] mar_v,
                         input logic [31:0] mdr_v, input logic [31:0] pc_v, input bit rdy,
                         input logic [31:0] rd, input bit rst);
        @(posedge clk);
        model_step();
        #1;
        issue     = iss;
        mem_ctrl  = ctrl;
        mar       = mar_v;
        mdr       = mdr_v;
        pc        = pc_v;
        mem_ready = rdy;
        mem_rdata = rd;
        reset     = rst;
    endtask

    task automatic idle(input bit rdy, input logic [31:0] rd);
        drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, rdy, rd, 1'b0);
    endtask

    initial begin
        int          stalls;
        logic [31:0] pcs[3];
        logic [7:0]  lanes_exp[3];
        logic [31:0] rm, rp;

        reset = 1'b1; issue = 1'b0; mem_ctrl = '0; mar = '0; mdr = '0; pc = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        drive(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, 1'b1);
        drive(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, 1'b1);
        idle(1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("reset_req", 32'(mem_req_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_mdr_data", mdr_data_o, 32'd0);

        // Simultaneous WRITE+FETCH: data first here, fetch first on the second instance.
        drive(1'b1, 3'b101, 32'h20, 32'hCAFE_F00D, 32'h8000_0006, 1'b0, 0, 1'b0);
        idle(1'b1, 32'hA1B2_C3D4);
        @(negedge clk);
        chk("wf_k1_we", 32'(mem_we_o), 32'd1);
        chk("wf_k1_addr", mem_addr_o, 32'h80);
        chk("wf_k1_stall", 32'(stall_o), 32'd1);
        chk("ff_k1_we", 32'(ff_we), 32'd0);
        chk("ff_k1_addr", ff_addr, 32'h8000_0004);
        idle(1'b1, 32'hA1B2_C3D4);
        @(negedge clk);
        chk("wf_k2_mbr", 32'(mbr_data_o), 32'hC3);
        chk("wf_k2_stall", 32'(stall_o), 32'd0);
        chk("ff_k2_we", 32'(ff_we), 32'd1);
        chk("ff_k2_addr", ff_addr, 32'h80);

        // Zero-wait read.
        drive(1'b1, 3'b010, 32'h10, 0, 0, 1'b0, 0, 1'b0);
        idle(1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_addr", mem_addr_o, 32'h40);
        chk("rd_we", 32'(mem_we_o), 32'd0);
        chk("rd_mdr_load", 32'(mdr_load_o), 32'd1);
        chk("rd_mdr_data", mdr_data_o, 32'hDEAD_BEEF);
        chk("rd_stall", 32'(stall_o), 32'd0);

        // Fetch byte lanes.
        pcs = '{32'h101, 32'h102, 32'h103};
        lanes_exp = '{8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b001, 0, 0, pcs[i], 1'b0, 0, 1'b0);
            idle(1'b1, 32'h1122_3344);
            @(negedge clk);
            chk("fetch_lane", 32'(mbr_data_o), 32'(lanes_exp[i]));
        end

        // Three wait states on a read.
        drive(1'b1, 3'b010, 32'h33, 0, 0, 1'b0, 0, 1'b0);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 32'h0);
            @(negedge clk);
            if (stall_o) stalls++;
            chk("wait_addr", mem_addr_o, 32'hCC);
            chk("wait_no_load", 32'(mdr_load_o), 32'd0);
        end
        idle(1'b1, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("wait_stall_cycles", 32'(stalls), 32'd3);
        chk("wait_load", 32'(mdr_load_o), 32'd1);
        chk("wait_stall_end", 32'(stall_o), 32'd0);

        // READ+WRITE: a single write, error sticks.
        drive(1'b1, 3'b110, 32'h5, 32'h1234_5678, 0, 1'b0, 0, 1'b0);
        idle(1'b1, 32'h5555_5555);
        @(negedge clk);
        chk("rw_we", 32'(mem_we_o), 32'd1);
        chk("rw_wdata", mem_wdata_o, 32'h1234_5678);
        chk("rw_no_mdr", 32'(mdr_load_o), 32'd0);
        idle(1'b1, 32'h0);
        @(negedge clk);
        chk("rw_err", 32'(err_o), 32'd1);
        chk("rw_single", 32'(mem_req_o), 32'd0);

        // Reset in the middle of a waiting request.
        drive(1'b1, 3'b010, 32'h7, 0, 0, 1'b0, 0, 1'b0);
        drive(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("mid_req_before", 32'(mem_req_o), 32'd1);
        idle(1'b0, 32'h0);
        @(negedge clk);
        chk("mid_req_after", 32'(mem_req_o), 32'd0);
        chk("mid_stall_after", 32'(stall_o), 32'd0);
        chk("mid_err_after", 32'(err_o), 32'd0);

`ifdef MIC1_FETCH_BUF_EN
        // Two fetches to one word cost one memory access; a write to it forces a refetch.
        drive(1'b1, 3'b001, 0, 0, 32'h9000, 1'b0, 0, 1'b0);
        drive(1'b1, 3'b001, 0, 0, 32'h9003, 1'b1, 32'h5566_7788, 1'b0);
        @(negedge clk);
        chk("buf_first_req", 32'(mem_req_o), 32'd1);
        chk("buf_first_mbr", 32'(mbr_data_o), 32'h55);
        idle(1'b0, 32'h0);
        @(negedge clk);
        chk("buf_hit_no_req", 32'(mem_req_o), 32'd0);
        chk("buf_hit_load", 32'(mbr_load_o), 32'd1);
        chk("buf_hit_mbr", 32'(mbr_data_o), 32'h88);
        drive(1'b1, 3'b100, 32'h2400, 32'h1, 0, 1'b0, 0, 1'b0);
        idle(1'b1, 32'h0);
        @(negedge clk);
        chk("buf_wr_addr", mem_addr_o, 32'h9000);
        drive(1'b1, 3'b001, 0, 0, 32'h9001, 1'b0, 0, 1'b0);
        idle(1'b1, 32'h0A0B_0C0D);
        @(negedge clk);
        chk("buf_refetch_req", 32'(mem_req_o), 32'd1);
        chk("buf_refetch_mbr", 32'(mbr_data_o), 32'h0B);
`endif

        // Random traffic; issues during stalls are offered and must be ignored.
        for (int i = 0; i < 3000; i++) begin
            rm = 32'($urandom_range(0, 15));
            rm[31:30] = 2'($urandom_range(0, 3));
            rp = 32'($urandom_range(0, 63));
            drive(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), rm, $urandom, rp,
                  ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 399) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 32'h0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
